// File: rtl/product_bcd_converter_if.sv
// Request/result bundle for product_bcd_converter: the requester drives start and
// product_in, the converter returns busy, the done pulse and the packed BCD result.
interface product_bcd_converter_if #(
  parameter int WIDTH  = 16,
  parameter int DIGITS = 5
);
  logic                  start;
  logic [WIDTH-1:0]      product_in;
  logic                  busy;
  logic                  done;
  logic [4*DIGITS-1:0]   bcd_out;
  logic                  sign;

  modport master (
    output start, product_in,
    input  busy, done, bcd_out, sign
  );

  modport slave (
    input  start, product_in,
    output busy, done, bcd_out, sign
  );
endinterface

// File: rtl/product_bcd_converter.sv
// Sequential binary-to-BCD converter (double dabble, one bit per clock) for a product value.
// Define PRODUCT_SIGNED_EN to treat product_in as two's complement and report its sign.
module product_bcd_converter #(
  parameter int WIDTH  = 16,
  // DIGITS must cover the largest magnitude: 10**DIGITS > 2**WIDTH - 1.
  parameter int DIGITS = 5
) (
  input  logic                          clk,
  input  logic                          reset_n,
  product_bcd_converter_if.slave        bus
);

  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam int BCD_W = 4 * DIGITS;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    FINISH
  } state_t;

  state_t              state;
  state_t              state_next;

  logic [WIDTH-1:0]    shift_q;
  logic [BCD_W-1:0]    acc_q;
  logic [CNT_W-1:0]    count_q;
  logic                captured_sign_q;

  logic                busy_q;
  logic                done_q;
  logic [BCD_W-1:0]    bcd_q;
  logic                sign_q;

  logic [WIDTH-1:0]    capture_mag;
  logic                capture_sign;
  logic [BCD_W-1:0]    acc_adj;
  logic                last_shift;

  // Magnitude and sign presented to the shift register on the accepted start edge.
`ifdef PRODUCT_SIGNED_EN
  logic capture_neg;

  assign capture_neg  = bus.product_in[WIDTH-1];
  // Negating 0x8000 wraps back to 0x8000, which read unsigned is exactly 32768.
  assign capture_mag  = capture_neg ? ({WIDTH{1'b0}} - bus.product_in) : bus.product_in;
  assign capture_sign = capture_neg & (|bus.product_in);
`else
  assign capture_mag  = bus.product_in;
  assign capture_sign = 1'b0;
`endif

  assign last_shift = (count_q == CNT_W'(WIDTH - 1));

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      // NOTE: registers take non-blocking assignments so every flop samples pre-edge values.
      state <= state_next;
    end
  end

  // Next-state logic.
  always_comb begin
    // NOTE: default first, so no path through the case leaves state_next unassigned (no latch).
    state_next = state;
    case (state)
      IDLE:    if (bus.start) state_next = SHIFT;
      SHIFT:   if (last_shift) state_next = FINISH;
      FINISH:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Add-3 correction on every BCD digit that will overflow past 9 when doubled.
  always_comb begin
    acc_adj = acc_q;
    for (int d = 0; d < DIGITS; d++) begin
      if (acc_q[4*d +: 4] >= 4'd5) begin
        acc_adj[4*d +: 4] = acc_q[4*d +: 4] + 4'd3;
      end
    end
  end

  // Datapath and result registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      // NOTE: every flop here is reset, including the working registers, so an abort leaves no residue.
      shift_q         <= '0;
      acc_q           <= '0;
      count_q         <= '0;
      captured_sign_q <= 1'b0;
      busy_q          <= 1'b0;
      done_q          <= 1'b0;
      bcd_q           <= '0;
      sign_q          <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            shift_q         <= capture_mag;
            acc_q           <= '0;
            count_q         <= '0;
            captured_sign_q <= capture_sign;
            busy_q          <= 1'b1;
          end
        end
        SHIFT: begin
          acc_q   <= {acc_adj[BCD_W-2:0], shift_q[WIDTH-1]};
          shift_q <= {shift_q[WIDTH-2:0], 1'b0};
          count_q <= count_q + 1'b1;
        end
        FINISH: begin
          // Only the finished accumulator ever reaches bcd_out.
          bcd_q  <= acc_q;
          sign_q <= captured_sign_q;
          done_q <= 1'b1;
          busy_q <= 1'b0;
        end
        default: begin
          busy_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.bcd_out = bcd_q;
  assign bus.sign    = sign_q;

endmodule

// File: tb/tb_product_bcd_converter.sv
// Self-checking bench for product_bcd_converter: directed spot values plus random traffic
// compared every cycle against a decimal-arithmetic model. Honours PRODUCT_SIGNED_EN.
module tb_product_bcd_converter;

  localparam int WIDTH  = 16;
  localparam int DIGITS = 5;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   checks = 0;
  int   errors = 0;
  bit   chk_en = 1'b0;

  product_bcd_converter_if #(.WIDTH(WIDTH), .DIGITS(DIGITS)) bus ();

  product_bcd_converter #(.WIDTH(WIDTH), .DIGITS(DIGITS)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic int unsigned magnitude(input logic [WIDTH-1:0] p);
`ifdef PRODUCT_SIGNED_EN
    if (p[WIDTH-1]) return (32'd1 << WIDTH) - 32'(p);
`endif
    return 32'(p);
  endfunction

  function automatic logic is_negative(input logic [WIDTH-1:0] p);
`ifdef PRODUCT_SIGNED_EN
    return p[WIDTH-1] && (p != '0);
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic [4*DIGITS-1:0] to_bcd(input int unsigned v);
    logic [4*DIGITS-1:0] r;
    r = '0;
    for (int i = 0; i < DIGITS; i++) begin
      r[4*i +: 4] = 4'(v % 10);
      v = v / 10;
    end
    return r;
  endfunction

  // Timeline model: a request accepted at edge E0 yields done in the cycle after edge E(WIDTH+1).
  int                  m_cnt;
  logic                m_busy, m_done, m_sign, m_pend_sign;
  logic [4*DIGITS-1:0] m_bcd, m_pend_bcd;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_cnt  <= 0;
      m_busy <= 1'b0;
      m_done <= 1'b0;
      m_bcd  <= '0;
      m_sign <= 1'b0;
    end else begin
      m_done <= 1'b0;
      if (m_cnt == 0) begin
        if (bus.start) begin
          m_cnt       <= 1;
          m_busy      <= 1'b1;
          m_pend_bcd  <= to_bcd(magnitude(bus.product_in));
          m_pend_sign <= is_negative(bus.product_in);
        end
      end else if (m_cnt == WIDTH + 1) begin
        m_cnt  <= 0;
        m_busy <= 1'b0;
        m_done <= 1'b1;
        m_bcd  <= m_pend_bcd;
        m_sign <= m_pend_sign;
      end else begin
        m_cnt <= m_cnt + 1;
      end
    end
  end

  // Every-cycle comparison against the model, sampled on the falling edge.
  always @(negedge clk) begin
    if (chk_en) begin
      check("busy",    32'(bus.busy),    32'(m_busy));
      check("done",    32'(bus.done),    32'(m_done));
      check("bcd_out", 32'(bus.bcd_out), 32'(m_bcd));
      check("sign",    32'(bus.sign),    32'(m_sign));
    end
  end

  // One conversion from idle; optional stray start at cycle glitch_at. Pins literal results.
  task automatic convert(input string name, input logic [WIDTH-1:0] v,
                         input logic [4*DIGITS-1:0] exp_bcd, input logic exp_sign,
                         input int glitch_at);
    int first_done = 0;
    int n_done = 0;
    bus.start      = 1'b1;
    bus.product_in = v;
    @(posedge clk); #1;
    bus.start      = 1'b0;
    bus.product_in = WIDTH'($urandom);
    for (int c = 1; c <= 30; c++) begin
      if (glitch_at != 0 && c == glitch_at) begin
        bus.start      = 1'b1;
        bus.product_in = ~v;
      end else begin
        bus.start = 1'b0;
      end
      @(negedge clk);
      if (bus.done) begin
        n_done++;
        if (n_done == 1) begin
          first_done = c;
          check({name, " bcd"},  32'(bus.bcd_out), 32'(exp_bcd));
          check({name, " sign"}, 32'(bus.sign),    32'(exp_sign));
        end
      end
      @(posedge clk); #1;
    end
    bus.start = 1'b0;
    check({name, " latency"},    32'(first_done), 32'd18);
    check({name, " done count"}, 32'(n_done),     32'd1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [WIDTH-1:0] v;
    bus.start      = 1'b0;
    bus.product_in = '0;
    reset_n        = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk_en = 1'b1;
    check("reset busy",    32'(bus.busy),    32'd0);
    check("reset done",    32'(bus.done),    32'd0);
    check("reset bcd_out", 32'(bus.bcd_out), 32'd0);
    check("reset sign",    32'(bus.sign),    32'd0);
    reset_n = 1'b1;

    convert("zero", 16'h0000, 20'h00000, 1'b0, 0);
`ifdef PRODUCT_SIGNED_EN
    convert("0x4000 stray start", 16'h4000, 20'h16384, 1'b0, 5);
    convert("0xC080", 16'hC080, 20'h16256, 1'b1, 0);
    convert("0x8000", 16'h8000, 20'h32768, 1'b1, 0);
    convert("0xFFFF", 16'hFFFF, 20'h00001, 1'b1, 0);
`else
    convert("0x4000 stray start", 16'h4000, 20'h16384, 1'b0, 5);
    convert("0xC080", 16'hC080, 20'h49280, 1'b0, 0);
    convert("0x8000", 16'h8000, 20'h32768, 1'b0, 0);
    convert("0xFFFF", 16'hFFFF, 20'h65535, 1'b0, 0);
`endif

    // Abort a conversion in its eighth shift cycle.
    bus.start      = 1'b1;
    bus.product_in = 16'h0AAA;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (7) @(posedge clk);
    #1;
    reset_n = 1'b0;
    #1;
    check("abort busy",    32'(bus.busy),    32'd0);
    check("abort done",    32'(bus.done),    32'd0);
    check("abort bcd_out", 32'(bus.bcd_out), 32'd0);
    check("abort sign",    32'(bus.sign),    32'd0);
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    convert("after reset 0x0123", 16'h0123, 20'h00291, 1'b0, 0);

    // Random traffic: stray starts, back-to-back requests, input churn, occasional resets.
    for (int cyc = 0; cyc < 2500; cyc++) begin
      case ($urandom_range(0, 7))
        0:       v = 16'h0000;
        1:       v = 16'h8000;
        2:       v = 16'hFFFF;
        3:       v = 16'h7FFF;
        default: v = WIDTH'($urandom);
      endcase
      bus.product_in = v;
      bus.start      = ($urandom_range(0, 2) == 0);
      reset_n        = ($urandom_range(0, 299) != 0);
      @(posedge clk); #1;
    end
    reset_n   = 1'b1;
    bus.start = 1'b0;
    repeat (25) @(posedge clk);
    #1;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/product_bcd_converter.md
PRODUCT_BCD_CONVERTER -- requirements
Module: product_bcd_converter

Interface
REQ-001 Parameter WIDTH, default 16: bit width of the binary product input.
REQ-002 Parameter DIGITS, default 5: number of packed BCD output digits; bcd_out width is 4*DIGITS.
REQ-003 The block SHALL use one clock and an asynchronous, active-low reset.
REQ-004 clk  input  1  system clock; all state updates on the rising edge.
REQ-005 reset_n  input  1  asynchronous active-low reset.
REQ-006 start  input  1  conversion request, sampled only in IDLE.
REQ-007 product_in  input  WIDTH  binary product, captured on the accepted start edge.
REQ-008 busy  output  1  high while a conversion is in progress.
REQ-009 done  output  1  single-cycle pulse: new result is valid on bcd_out/sign.
REQ-010 bcd_out  output  4*DIGITS  packed BCD magnitude, digit 0 in bits [3:0].
REQ-011 sign  output  1  high when the converted value is negative.

Function
REQ-012 FSM states SHALL be IDLE, SHIFT and FINISH, with reset entering IDLE.
REQ-013 In IDLE with start=1 at edge E0, the block SHALL capture |product_in| into the shift register, clear the BCD accumulator and shift counter, set busy, and enter SHIFT.
REQ-014 Each SHIFT cycle SHALL add 3 to every BCD digit >= 5, then shift {accumulator, shift register} left by one (double dabble).
REQ-015 After exactly WIDTH SHIFT cycles (edges E1..E_WIDTH), the FSM SHALL enter FINISH.
REQ-016 In FINISH, the block SHALL register the accumulator into bcd_out and the captured sign into sign, pulse done for exactly one cycle, clear busy, and return to IDLE on the next edge.
REQ-017 Latency: with WIDTH=16, done SHALL be high in the cycle after edge E17; back-to-back throughput is one result per 18 clocks.
REQ-018 start SHALL be ignored while busy=1 or in FINISH; no queuing.
REQ-019 start asserted in the cycle after done SHALL be accepted normally.
REQ-020 bcd_out and sign SHALL hold their last result between done pulses; intermediate accumulator values SHALL never appear on bcd_out.
REQ-021 The magnitude SHALL be an unsigned WIDTH-bit value, so the most-negative input converts correctly (0x8000 -> 32768).
REQ-022 Zero input SHALL always produce sign=0.
REQ-023 product_in changes after the accepted start edge SHALL NOT affect the result.

Reset
REQ-024 reset_n low SHALL immediately force IDLE with busy=0, done=0, sign=0, bcd_out=0, and the shift register, accumulator and counter cleared.
REQ-025 Reset during SHIFT or FINISH SHALL abort the conversion with no done pulse.
REQ-026 After reset_n rises, the first start SHALL be accepted on the next rising edge.

Configuration
REQ-027 Macro PRODUCT_SIGNED_EN.
- Defined: product_in is two's complement, the magnitude is its absolute value, and sign = product_in[WIDTH-1] captured at start, gated by REQ-022.
- Undefined: product_in is unsigned, the magnitude is product_in unchanged, and sign is tied to 0.
REQ-028 With either macro setting, DIGITS SHALL satisfy 10^DIGITS > 2^WIDTH - 1; the defaults satisfy this.

Verification
REQ-029 Signed build: product_in=0x0000, start -> done after 17 edges; bcd_out=0x00000, sign=0.
REQ-030 Signed build: 0x4000 -> bcd_out=0x16384, sign=0; then 0xC080 -> bcd_out=0x16256, sign=1.
REQ-031 Signed build: 0x8000 -> bcd_out=0x32768, sign=1; 0xFFFF -> bcd_out=0x00001, sign=1.
REQ-032 start pulsed at SHIFT cycle 5 with a different product_in -> ignored; the first result is correct and there is exactly one done pulse.
REQ-033 reset_n low at SHIFT cycle 8 -> all outputs are 0 immediately and no done pulse occurs; a new start then converts 0x0123 -> bcd_out=0x00291.
REQ-034 Unsigned build (macro undefined): 0xFFFF -> bcd_out=0x65535, sign=0.
